instr_encoder: RTL and testbench

Streaming RV32I instruction encoder: accepts decoded fields (format, registers, funct codes, 32-bit immediate) over a valid/ready handshake and emits packed 32-bit instruction words, the inverse of the decode-side immediate generator. It also expands the LI pseudo-op into ADDI, LUI, or LUI+ADDI. It sits between the test/boot program generator and instruction memory write port.

---
 rtl/rv32i_pkg.sv | 43 ++++
 rtl/instr_pack.sv | 62 ++++++
 rtl/instr_encoder.sv | 157 +++++++++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encode/decode definitions: instruction formats, opcodes and
// the immediate range check used by the encoder.
package rv32i_pkg;

  typedef enum logic [3:0] {
    FMT_R     = 4'd0,
    FMT_I     = 4'd1,
    FMT_LOAD  = 4'd2,
    FMT_JALR  = 4'd3,
    FMT_S     = 4'd4,
    FMT_B     = 4'd5,
    FMT_LUI   = 4'd6,
    FMT_AUIPC = 4'd7,
    FMT_J     = 4'd8,
    FMT_LI    = 4'd9
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_OUT2 = 2'd2
  } enc_state_e;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_J     = 7'h6F;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when v[31:sh] are all equal, i.e. v sign-extends from bit sh.
  function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] sh);
    logic [31:0] t;
    t = $signed(v) >>> sh;
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: places register/funct/immediate fields
// for one format and flags immediates the format cannot represent.
module instr_pack
  import rv32i_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic [6:0] i_op;
  logic [2:0] i_f3;

  assign i_op = (fmt_i == FMT_LOAD) ? OP_LOAD :
                (fmt_i == FMT_JALR) ? OP_JALR : OP_I;
  assign i_f3 = (fmt_i == FMT_JALR) ? 3'b000 : funct3_i;

  always_comb begin
    instr_o = NOP;
    err_o   = 1'b0;
    case (fmt_i)
      FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      FMT_I, FMT_LOAD, FMT_JALR: begin
        if (fits_signed(imm_i, 5'd11)) instr_o = {imm_i[11:0], rs1_i, i_f3, rd_i, i_op};
        else                           err_o   = 1'b1;
      end
      FMT_S: begin
        if (fits_signed(imm_i, 5'd11))
          instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
        else
          err_o = 1'b1;
      end
      FMT_B: begin
        if (fits_signed(imm_i, 5'd12) && !imm_i[0])
          instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OP_B};
        else
          err_o = 1'b1;
      end
      FMT_LUI, FMT_AUIPC: begin
        if (imm_i[11:0] == 12'h000)
          instr_o = {imm_i[31:12], rd_i, (fmt_i == FMT_LUI) ? OP_LUI : OP_AUIPC};
        else
          err_o = 1'b1;
      end
      FMT_J: begin
        if (fits_signed(imm_i, 5'd20) && !imm_i[0])
          instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_J};
        else
          err_o = 1'b1;
      end
      // LI is expanded upstream; any other code is unknown.
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: valid/ready request in, registered instruction
// word out, with LI expanded to ADDI, LUI or LUI+ADDI.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fmt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  enc_state_e       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [4:0]       rd2_q, rd2_d;
  logic [11:0]      lo2_q, lo2_d;

  logic        is_li, li_fits, li_two;
  logic [11:0] li_lo;
  logic [19:0] li_hi;

  fmt_e        p_fmt;
  logic [4:0]  p_rd, p_rs1;
  logic [2:0]  p_f3;
  logic [31:0] p_imm, p_instr;
  logic        p_err;
  logic        acc, hs, load_req;

  assign is_li   = (in_fmt == FMT_LI);
  assign li_fits = fits_signed(in_imm, 5'd11);
  assign li_lo   = in_imm[11:0];
  // hi is rounded up when lo is negative so LUI+ADDI lands on the value.
  assign li_hi   = in_imm[31:12] + {19'b0, in_imm[11]};
  assign li_two  = !li_fits && (li_lo != 12'h000);

  assign out_valid = (state_q != ST_IDLE);
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_count = cnt_q;

  assign in_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_OUT) && !pend_q && out_ready);
  assign acc = in_valid && in_ready;
  assign hs  = out_valid && out_ready;

  // Packer input: the latched ADDI half of an LI while it is due, else the request.
  always_comb begin
    p_fmt = fmt_e'(in_fmt);
    p_rd  = in_rd;
    p_rs1 = in_rs1;
    p_f3  = in_funct3;
    p_imm = in_imm;
    if ((state_q == ST_OUT) && pend_q) begin
      p_fmt = FMT_I;
      p_rd  = rd2_q;
      p_rs1 = rd2_q;
      p_f3  = 3'b000;
      p_imm = {{20{lo2_q[11]}}, lo2_q};
    end else if (is_li) begin
      if (li_fits) begin
        p_fmt = FMT_I;
        p_rs1 = 5'd0;
        p_f3  = 3'b000;
      end else begin
        p_fmt = FMT_LUI;
        p_imm = {li_hi, 12'h000};
      end
    end
  end

  instr_pack u_pack (
    .fmt_i    (p_fmt),
    .rd_i     (p_rd),
    .rs1_i    (p_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (p_f3),
    .funct7_i (in_funct7),
    .imm_i    (p_imm),
    .instr_o  (p_instr),
    .err_o    (p_err)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    err_d    = err_q;
    pend_d   = pend_q;
    rd2_d    = rd2_q;
    lo2_d    = lo2_q;
    cnt_d    = cnt_q + CNT_W'(hs);
    load_req = 1'b0;
    case (state_q)
      ST_IDLE: load_req = acc;
      ST_OUT: begin
        if (hs) begin
          if (pend_q) begin
            state_d = ST_OUT2;
            instr_d = p_instr;
            err_d   = p_err;
            pend_d  = 1'b0;
          end else if (acc) begin
            load_req = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OUT2: if (hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load_req) begin
      state_d = ST_OUT;
      instr_d = p_instr;
      err_d   = p_err;
      pend_d  = is_li && li_two;
      rd2_d   = in_rd;
      lo2_d   = li_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      rd2_q   <= '0;
      lo2_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rd2_q   <= rd2_d;
      lo2_q   <= lo2_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: requests push expected words computed
// from the RV32I encoding rules; a monitor pops them on every output handshake.
module tb_instr_encoder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_fmt = '0;
  logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;
  bit          rand_rdy = 1'b0;
  logic [32:0] expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: {err, word} list straight from the format rules.
  function automatic void model(input logic [3:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, output int n,
                                output logic [32:0] w0, output logic [32:0] w1);
    longint      si;
    logic [31:0] lo, hi;
    si = $signed(imm);
    n  = 1;
    w0 = {1'b1, 32'h0000_0013};
    w1 = '0;
    case (f)
      4'd0: w0 = {1'b0, f7, rs2, rs1, f3, rd, 7'h33};
      4'd1, 4'd2, 4'd3:
        if (si >= -2048 && si <= 2047)
          w0 = {1'b0, imm[11:0], rs1, (f == 4'd3) ? 3'b000 : f3, rd,
                (f == 4'd1) ? 7'h13 : (f == 4'd2) ? 7'h03 : 7'h67};
      4'd4:
        if (si >= -2048 && si <= 2047) w0 = {1'b0, imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
      4'd5:
        if (si >= -4096 && si <= 4095 && imm[0] == 1'b0)
          w0 = {1'b0, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
      4'd6, 4'd7:
        if (imm % 4096 == 0) w0 = {1'b0, imm[31:12], rd, (f == 4'd6) ? 7'h37 : 7'h17};
      4'd8:
        if (si >= -1048576 && si <= 1048575 && imm[0] == 1'b0)
          w0 = {1'b0, imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
      4'd9: begin
        if (si >= -2048 && si <= 2047) begin
          w0 = {1'b0, imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          lo = imm & 32'h0000_0FFF;
          hi = (imm + 32'h0000_0800) >> 12;
          w0 = {1'b0, hi[19:0], rd, 7'h37};
          if (lo != 0) begin
            n  = 2;
            w1 = {1'b0, lo[11:0], rd, 3'b000, rd, 7'h13};
          end
        end
      end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_cnt = 0;
    end else if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%h err=%0d", out_instr, out_err);
      end else begin
        e = expq.pop_front();
        chk("word", {31'b0, out_err, out_instr}, {31'b0, e});
      end
      chk("out_count", 64'(out_count), 64'(exp_cnt % (1 << CNT_W)));
      exp_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // nd > 0 overrides the model with directed expected words.
  task automatic send(input logic [3:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input int nd, input logic [32:0] d0,
                      input logic [32:0] d1);
    int          n;
    logic [32:0] w0, w1;
    bit          ok;
    ok = 1'b0;
    model(f, rd, rs1, rs2, f3, f7, imm, n, w0, w1);
    if (nd > 0) begin
      n = nd; w0 = d0; w1 = d1;
    end
    in_valid = 1'b1; in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(w0);
        if (n == 2) expq.push_back(w1);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=in_ready_low exp=accept");
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          c0;
    logic [31:0] imm;
    logic [3:0]  f;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;

    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, {1'b0, 32'h0050_0093}, '0);
    send(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1, {1'b0, 32'h0020_8463}, '0);
    send(4'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1, {1'b1, 32'h0000_0013}, '0);
    send(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678, 2,
         {1'b0, 32'h1234_52B7}, {1'b0, 32'h6782_8293});
    @(negedge clk);
    chk("li_ready_first", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("li_ready_second", 64'(in_ready), 64'd0);
    chk("li_second_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    send(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0FFF, 2,
         {1'b0, 32'h0000_10B7}, {1'b0, 32'hFFF0_8093});
    send(4'd9, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_0000, 1, {1'b0, 32'h0001_01B7}, '0);
    wait_drain();

    // Backpressure: word held while the next request waits.
    out_ready = 1'b0;
    send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, {1'b0, 32'h0050_0093}, '0);
    in_valid = 1'b1; in_fmt = 4'd1; in_rd = 5'd2; in_imm = 32'd7;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_instr", 64'(out_instr), 64'h0050_0093);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 0, '0, '0);
    wait_drain();

    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(4'd1, 5'(i + 1), 5'(i), 5'd0, 3'(i), 7'd0, 32'(i * 17), 0, '0, '0);
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);
    wait_drain();

    // Reset between the two LI words.
    in_valid = 1'b1; in_fmt = 4'd9; in_rd = 5'd5; in_rs1 = 5'd0; in_funct3 = 3'd0;
    in_imm = 32'h1234_5678;
    @(negedge clk);
    chk("li_rst_accept", 64'(in_ready), 64'd1);
    expq.push_back({1'b0, 32'h1234_52B7});
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_instr", 64'(out_instr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("no_second_word", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      f = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      case ($urandom_range(0, 3))
        0:       imm = $urandom_range(0, 6000) - 32'd3000;
        1:       imm = $urandom() & 32'hFFFF_F000;
        2:       imm = $urandom();
        default: imm = ($urandom_range(0, 2097152) - 32'd1048576) & ~32'($urandom_range(0, 1));
      endcase
      send(f, 5'($urandom()), 5'($urandom()), 5'($urandom()), 3'($urandom()),
           7'($urandom()), imm, 0, '0, '0);
    end
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();
    chk("queue_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
